if_fetch_queue: RTL and testbench

- Small FIFO sitting directly downstream of the instruction-fetch stage's IF/ID pipeline register.
- Buffers fetched words {instruction, PCA, CIA} so decode can stall without freezing fetch on every cycle.
- Flushes on redirects.
- Drives no_new_fetch back to the fetch stage as almost-full backpressure.

---
 rtl/if_fetch_queue.sv | 108 ++++++++++
 tb/tb_if_fetch_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// FWFT queue behind the IF/ID register: a word written on edge N is at the head during cycle N+1.
// Decode stalls via rd_ready=0; no_new_fetch asserts at AFULL so the in-flight word still fits.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int AFULL = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FREEZE,
  input  logic          FLUSH,
  input  logic          wr_valid,
  input  logic [31:0]   Instr_in,
  input  logic [31:0]   PCA_in,
  input  logic [31:0]   CIA_in,
  input  logic          rd_ready,
  output logic [31:0]   Instr_out,
  output logic [31:0]   PCA_out,
  output logic [31:0]   CIA_out,
  output logic          valid_out,
  output logic          no_new_fetch,
  output logic [AW:0]   count,
  output logic          ovf_err
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pca;
    logic [31:0] cia;
  } word_t;

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL);

  word_t         mem_q [DEPTH];
  word_t         mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_err_q, ovf_err_d;
  logic          do_rd, do_wr;
  word_t         head;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_err_d = ovf_err_q;
    do_rd     = 1'b0;
    do_wr     = 1'b0;
    if (!FREEZE) begin
      if (FLUSH) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        do_rd = rd_ready && (count_q != '0);
        // A read in the same cycle frees the slot, so a full queue still accepts.
        do_wr = wr_valid && ((count_q < FULL_CNT) || do_rd);
        if (wr_valid && !do_wr)
          ovf_err_d = 1'b1;
        if (do_wr) begin
          mem_d[wr_ptr_q] = '{instr: Instr_in, pca: PCA_in, cia: CIA_in};
          wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd)
          rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr && !do_rd)
          count_d = count_q + (AW+1)'(1);
        else if (do_rd && !do_wr)
          count_d = count_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  always_comb begin
    head = '0;
    if (count_q != '0)
      head = mem_q[rd_ptr_q];
  end

  assign Instr_out    = head.instr;
  assign PCA_out      = head.pca;
  assign CIA_out      = head.cia;
  assign valid_out    = (count_q != '0);
  assign no_new_fetch = (count_q >= AFULL_CNT);
  assign count        = count_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed plan plus random traffic against a queue-based model of the fetch queue.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int AFULL = 3;

  logic        CLK, RESET, FREEZE, FLUSH, wr_valid, rd_ready;
  logic [31:0] Instr_in, PCA_in, CIA_in;
  logic [31:0] Instr_out, PCA_out, CIA_out;
  logic        valid_out, no_new_fetch, ovf_err;
  logic [AW:0] count;

  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .AFULL(AFULL)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH),
    .wr_valid(wr_valid), .Instr_in(Instr_in), .PCA_in(PCA_in), .CIA_in(CIA_in),
    .rd_ready(rd_ready), .Instr_out(Instr_out), .PCA_out(PCA_out), .CIA_out(CIA_out),
    .valid_out(valid_out), .no_new_fetch(no_new_fetch), .count(count), .ovf_err(ovf_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [95:0] mq[$];
  logic        m_ovf;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [95:0] h;
    h = (mq.size() != 0) ? mq[0] : 96'h0;
    check({tag, ".count"}, 96'(count), 96'(mq.size()));
    check({tag, ".valid"}, 96'(valid_out), 96'(mq.size() != 0));
    check({tag, ".nnf"},   96'(no_new_fetch), 96'(mq.size() >= AFULL));
    check({tag, ".ovf"},   96'(ovf_err), 96'(m_ovf));
    check({tag, ".head"},  {Instr_out, PCA_out, CIA_out}, h);
  endtask

  // Reference behaviour for one rising edge.
  task automatic model_edge(input logic fr, input logic fl, input logic wv,
                            input logic [95:0] w, input logic rr);
    if (fr) return;
    if (fl) begin
      mq.delete();
      return;
    end
    if (rr && mq.size() > 0) void'(mq.pop_front());
    if (wv) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input string tag, input logic fr, input logic fl, input logic wv,
                      input logic [95:0] w, input logic rr);
    FREEZE = fr; FLUSH = fl; wr_valid = wv; rd_ready = rr;
    {Instr_in, PCA_in, CIA_in} = w;
    @(posedge CLK);
    model_edge(fr, fl, wv, w, rr);
    @(negedge CLK);
    check_all(tag);
  endtask

  // Called at a negedge: reset pulse strictly between clock edges.
  task automatic reset_pulse(input string tag);
    #1 RESET = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_all(tag);
    #1 RESET = 1'b1;
    @(negedge CLK);
  endtask

  function automatic logic [95:0] mk(input int i);
    logic [31:0] ins, pca, cia;
    ins = 32'h11111111 * i;
    pca = 32'h100 + 32'(4 * (i - 1));
    cia = 32'h200 + 32'(4 * (i - 1));
    return {ins, pca, cia};
  endfunction

  function automatic logic [95:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    RESET = 1'b0; FREEZE = 1'b0; FLUSH = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    Instr_in = '0; PCA_in = '0; CIA_in = '0;
    m_ovf = 1'b0;
    #2 check_all("reset");
    @(negedge CLK);
    RESET = 1'b1;

    // Fill to the almost-full threshold.
    for (int i = 1; i <= 3; i++) step("fill", 0, 0, 1, mk(i), 0);
    check("fill3.instr", 96'(Instr_out), 96'h11111111);
    check("fill3.pca", 96'(PCA_out), 96'h100);
    check("fill3.nnf", 96'(no_new_fetch), 96'h1);

    // Fourth word fills, fifth overflows.
    step("w4", 0, 0, 1, mk(4), 0);
    step("w5", 0, 0, 1, mk(5), 0);
    check("ovf.flag", 96'(ovf_err), 96'h1);
    check("ovf.count", 96'(count), 96'h4);
    for (int i = 1; i <= 4; i++) begin
      check("drain.order", 96'(Instr_out), 96'(32'h11111111 * i));
      step("drain", 0, 0, 0, '0, 1);
    end
    check("drain.empty", 96'(valid_out), 96'h0);

    // Full-queue streaming through pointer wrap, with ovf cleared first.
    reset_pulse("rst2");
    for (int i = 1; i <= 4; i++) step("refill", 0, 0, 1, mk(i), 0);
    for (int i = 5; i <= 14; i++) step("stream", 0, 0, 1, mk(i), 1);
    check("stream.ovf", 96'(ovf_err), 96'h0);
    check("stream.head", 96'(Instr_out), 96'(32'h11111111 * 11));
    for (int i = 0; i < 4; i++) step("stream.drain", 0, 0, 0, '0, 1);

    // Read/write together on empty.
    step("empty.rw", 0, 0, 1, mk(7), 1);
    check("empty.rw.cnt", 96'(count), 96'h1);
    step("rd.empty", 0, 0, 0, '0, 1);
    step("rd.empty2", 0, 0, 0, '0, 1);

    // Flush discards stored entries and the same-cycle write.
    step("f1", 0, 0, 1, mk(1), 0);
    step("f2", 0, 0, 1, mk(2), 0);
    step("flush", 0, 1, 1, mk(3), 1);
    check("flush.cnt", 96'(count), 96'h0);
    step("postflush", 0, 0, 1, mk(9), 0);
    check("postflush.head", 96'(Instr_out), 96'(32'h11111111 * 9));

    // Freeze holds everything.
    step("fz.pre", 0, 0, 1, mk(2), 0);
    for (int i = 0; i < 3; i++) step("freeze", 1, 1, 1, rnd(), 1);
    check("freeze.cnt", 96'(count), 96'h2);
    check("freeze.head", 96'(Instr_out), 96'(32'h11111111 * 9));
    step("unfreeze", 0, 0, 1, mk(3), 1);
    check("unfreeze.head", 96'(Instr_out), 96'(32'h11111111 * 2));

    // Async reset mid-operation, then first write after release.
    step("rst.pre", 0, 0, 0, '0, 0);
    reset_pulse("rst.mid");
    step("rst.post", 0, 0, 1, mk(5), 0);
    check("rst.post.head", 96'(Instr_out), 96'h55555555);

    // Random traffic, including null words.
    for (int i = 0; i < 400; i++) begin
      logic [95:0] w;
      w = ($urandom_range(0, 9) == 0) ? {32'h0, $urandom, $urandom} : rnd();
      step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6), w, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
